// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pipe
//  Desc     : MIPS-style control decode with ID/EX, EX/MEM and MEM/WB control
//             registers, stall/flush/bubble handling and a saturating
//             illegal-opcode counter. Optional JAL decode: CTRL_PIPE_JAL_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipe #(
  parameter int OPCODE_W  = 6,
  parameter int ALUOP_W   = 6,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 stall,
  input  logic                 bubble,
  input  logic                 flush,
  output logic                 ex_valid,
  output logic [ALUOP_W-1:0]   ex_aluop,
  output logic                 ex_alusrc,
  output logic                 ex_regdst,
  output logic                 ex_branch_eq,
  output logic                 ex_branch_ne,
  output logic                 ex_jump,
  output logic                 mem_valid,
  output logic                 mem_memread,
  output logic                 mem_memwrite,
  output logic                 wb_valid,
  output logic                 wb_regwrite,
  output logic                 wb_memtoreg,
  output logic                 wb_link,
  output logic [ILL_CNT_W-1:0] ill_cnt
);

  // Opcode encodings (MIPS primary opcode field)
  localparam logic [OPCODE_W-1:0] c_op_rtype = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] c_op_j     = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] c_op_beq   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] c_op_bne   = OPCODE_W'(6'b000101);
  localparam logic [OPCODE_W-1:0] c_op_addi  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] c_op_lw    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] c_op_sw    = OPCODE_W'(6'b101011);
`ifdef CTRL_PIPE_JAL_EN
  localparam logic [OPCODE_W-1:0] c_op_jal   = OPCODE_W'(6'b000011);
`endif

  typedef struct packed {
    logic [ALUOP_W-1:0] aluop;
    logic               alusrc;
    logic               regdst;
    logic               branch_eq;
    logic               branch_ne;
    logic               jump;
  } ex_ctl_t;

  typedef struct packed {
    logic memread;
    logic memwrite;
  } mem_ctl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
`ifdef CTRL_PIPE_JAL_EN
    logic link;
`endif
  } wb_ctl_t;

  typedef struct packed {
    logic     valid;
    ex_ctl_t  ex;
    mem_ctl_t mem;
    wb_ctl_t  wb;
  } idex_t;

  typedef struct packed {
    logic     valid;
    mem_ctl_t mem;
    wb_ctl_t  wb;
  } exmem_t;

  typedef struct packed {
    logic    valid;
    wb_ctl_t wb;
  } memwb_t;

  localparam idex_t  c_nop_idex  = '0;
  localparam exmem_t c_nop_exmem = '0;
  localparam memwb_t c_nop_memwb = '0;

  idex_t                r_idex;
  exmem_t               r_exmem;
  memwb_t               r_memwb;
  logic [ILL_CNT_W-1:0] r_ill_cnt;

  idex_t  w_dec;
  logic   w_legal;
  exmem_t w_idex_fwd;
  memwb_t w_exmem_fwd;

  always_comb begin
    w_dec   = c_nop_idex;
    w_legal = 1'b1;
    case (opcode)
      c_op_lw: begin
        w_dec.valid        = 1'b1;
        w_dec.ex.alusrc    = 1'b1;
        w_dec.mem.memread  = 1'b1;
        w_dec.wb.memtoreg  = 1'b1;
        w_dec.wb.regwrite  = 1'b1;
      end
      c_op_sw: begin
        w_dec.valid        = 1'b1;
        w_dec.ex.alusrc    = 1'b1;
        w_dec.mem.memwrite = 1'b1;
      end
      c_op_addi: begin
        w_dec.valid        = 1'b1;
        w_dec.ex.alusrc    = 1'b1;
        w_dec.wb.regwrite  = 1'b1;
      end
      c_op_rtype: begin
        w_dec.valid        = 1'b1;
        w_dec.ex.regdst    = 1'b1;
        w_dec.wb.regwrite  = 1'b1;
      end
      c_op_beq: begin
        w_dec.valid        = 1'b1;
        w_dec.ex.branch_eq = 1'b1;
      end
      c_op_bne: begin
        w_dec.valid        = 1'b1;
        w_dec.ex.branch_ne = 1'b1;
      end
      c_op_j: begin
        w_dec.valid        = 1'b1;
        w_dec.ex.jump      = 1'b1;
      end
`ifdef CTRL_PIPE_JAL_EN
      c_op_jal: begin
        w_dec.valid        = 1'b1;
        w_dec.ex.jump      = 1'b1;
        w_dec.wb.regwrite  = 1'b1;
        w_dec.wb.link      = 1'b1;
      end
`endif
      default: w_legal = 1'b0;
    endcase
    // Illegal opcodes keep the all-zero NOP word, including aluop
    if (w_dec.valid) begin
      w_dec.ex.aluop = ALUOP_W'(opcode);
    end
  end

  assign w_idex_fwd  = '{valid: r_idex.valid,  mem: r_idex.mem, wb: r_idex.wb};
  assign w_exmem_fwd = '{valid: r_exmem.valid, wb: r_exmem.wb};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idex    <= c_nop_idex;
      r_exmem   <= c_nop_exmem;
      r_memwb   <= c_nop_memwb;
      r_ill_cnt <= '0;
    end else if (stall) begin
      r_idex    <= r_idex;
      r_exmem   <= r_exmem;
      r_memwb   <= r_memwb;
      r_ill_cnt <= r_ill_cnt;
    end else if (flush) begin
      r_idex    <= c_nop_idex;
      r_exmem   <= c_nop_exmem;
      r_memwb   <= w_exmem_fwd;
    end else if (bubble) begin
      r_idex    <= c_nop_idex;
      r_exmem   <= w_idex_fwd;
      r_memwb   <= w_exmem_fwd;
    end else begin
      r_idex    <= w_dec;
      r_exmem   <= w_idex_fwd;
      r_memwb   <= w_exmem_fwd;
      if (!w_legal && !(&r_ill_cnt)) begin
        r_ill_cnt <= r_ill_cnt + 1'b1;
      end
    end
  end

  assign ex_valid     = r_idex.valid;
  assign ex_aluop     = r_idex.ex.aluop;
  assign ex_alusrc    = r_idex.ex.alusrc;
  assign ex_regdst    = r_idex.ex.regdst;
  assign ex_branch_eq = r_idex.ex.branch_eq;
  assign ex_branch_ne = r_idex.ex.branch_ne;
  assign ex_jump      = r_idex.ex.jump;
  assign mem_valid    = r_exmem.valid;
  assign mem_memread  = r_exmem.mem.memread;
  assign mem_memwrite = r_exmem.mem.memwrite;
  assign wb_valid     = r_memwb.valid;
  assign wb_regwrite  = r_memwb.wb.regwrite;
  assign wb_memtoreg  = r_memwb.wb.memtoreg;
`ifdef CTRL_PIPE_JAL_EN
  assign wb_link      = r_memwb.wb.link;
`else
  assign wb_link      = 1'b0;
`endif
  assign ill_cnt      = r_ill_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ctrl_pipe
//  Desc     : Self-checking bench for ctrl_pipe (vector table + corner cases).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe;

  localparam logic [5:0] c_lw = 6'b100011, c_sw = 6'b101011, c_addi = 6'b001000;
  localparam logic [5:0] c_beq = 6'b000100, c_bne = 6'b000101, c_rt = 6'b000000;
  localparam logic [5:0] c_j = 6'b000010, c_jal = 6'b000011, c_ill = 6'b111111;

  // EX word {valid, aluop[5:0], alusrc, regdst, beq, bne, jump}
  localparam logic [11:0] x_nop = 12'h000;
  localparam logic [11:0] x_lw = {1'b1, 6'b100011, 5'b10000};
  localparam logic [11:0] x_sw = {1'b1, 6'b101011, 5'b10000};
  localparam logic [11:0] x_addi = {1'b1, 6'b001000, 5'b10000};
  localparam logic [11:0] x_beq = {1'b1, 6'b000100, 5'b00100};
  localparam logic [11:0] x_bne = {1'b1, 6'b000101, 5'b00010};
  localparam logic [11:0] x_rt = {1'b1, 6'b000000, 5'b01000};
  localparam logic [11:0] x_j = {1'b1, 6'b000010, 5'b00001};
  // MEM word {valid, memread, memwrite}
  localparam logic [2:0] m_nop = 3'b000, m_lw = 3'b110, m_sw = 3'b101, m_oth = 3'b100;
  // WB word {valid, regwrite, memtoreg, link}
  localparam logic [3:0] w_nop = 4'b0000, w_lw = 4'b1110, w_rw = 4'b1100, w_oth = 4'b1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       stall, bubble, flush;
  logic       ex_valid, ex_alusrc, ex_regdst, ex_branch_eq, ex_branch_ne, ex_jump;
  logic [5:0] ex_aluop;
  logic       mem_valid, mem_memread, mem_memwrite;
  logic       wb_valid, wb_regwrite, wb_memtoreg, wb_link;
  logic [7:0] ill_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_pipe #(.OPCODE_W(6), .ALUOP_W(6), .ILL_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .stall(stall), .bubble(bubble), .flush(flush),
    .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc), .ex_regdst(ex_regdst),
    .ex_branch_eq(ex_branch_eq), .ex_branch_ne(ex_branch_ne), .ex_jump(ex_jump),
    .mem_valid(mem_valid), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
    .wb_link(wb_link), .ill_cnt(ill_cnt)
  );

  typedef struct {
    logic       rst_n;
    logic       stall;
    logic       bubble;
    logic       flush;
    logic [5:0] op;
    logic [11:0] ex;
    logic [2:0] mem;
    logic [3:0] wb;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic r, input logic s, input logic b, input logic f,
                              input logic [5:0] o, input logic [11:0] x,
                              input logic [2:0] m, input logic [3:0] w, input logic [7:0] c);
    vec_t v;
    v.rst_n = r; v.stall = s; v.bubble = b; v.flush = f; v.op = o;
    v.ex = x; v.mem = m; v.wb = w; v.cnt = c;
    return v;
  endfunction

  function automatic logic [11:0] obs_ex();
    return {ex_valid, ex_aluop, ex_alusrc, ex_regdst, ex_branch_eq, ex_branch_ne, ex_jump};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic f,
                       input logic [5:0] o);
    rst = r; stall = s; bubble = b; flush = f; opcode = o;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [11:0] x, input logic [2:0] m,
                           input logic [3:0] w, input logic [7:0] c);
    check({tag, "_ex"},  32'(obs_ex()), 32'(x));
    check({tag, "_mem"}, 32'({mem_valid, mem_memread, mem_memwrite}), 32'(m));
    check({tag, "_wb"},  32'({wb_valid, wb_regwrite, wb_memtoreg, wb_link}), 32'(w));
    check({tag, "_cnt"}, 32'(ill_cnt), 32'(c));
  endtask

  initial begin
    //            rst  stl  bub  fl   op      ex      mem    wb     cnt
    vecs[0]  = mk(1'b0,1'b0,1'b0,1'b0,c_rt,   x_nop,  m_nop, w_nop, 8'd0);
    vecs[1]  = mk(1'b1,1'b0,1'b0,1'b0,c_lw,   x_lw,   m_nop, w_nop, 8'd0);
    vecs[2]  = mk(1'b1,1'b0,1'b0,1'b0,c_sw,   x_sw,   m_lw,  w_nop, 8'd0);
    vecs[3]  = mk(1'b1,1'b0,1'b0,1'b0,c_addi, x_addi, m_sw,  w_lw,  8'd0);
    vecs[4]  = mk(1'b1,1'b0,1'b0,1'b0,c_beq,  x_beq,  m_oth, w_oth, 8'd0);
    vecs[5]  = mk(1'b1,1'b0,1'b0,1'b0,c_bne,  x_bne,  m_oth, w_rw,  8'd0);
    vecs[6]  = mk(1'b1,1'b0,1'b0,1'b0,c_rt,   x_rt,   m_oth, w_oth, 8'd0);
    vecs[7]  = mk(1'b1,1'b0,1'b0,1'b0,c_j,    x_j,    m_oth, w_oth, 8'd0);
    vecs[8]  = mk(1'b1,1'b0,1'b1,1'b0,c_lw,   x_nop,  m_oth, w_rw,  8'd0);
    vecs[9]  = mk(1'b1,1'b0,1'b0,1'b0,c_ill,  x_nop,  m_nop, w_oth, 8'd1);
    vecs[10] = mk(1'b1,1'b1,1'b0,1'b0,c_ill,  x_nop,  m_nop, w_oth, 8'd1);
    vecs[11] = mk(1'b1,1'b0,1'b0,1'b1,c_ill,  x_nop,  m_nop, w_nop, 8'd1);
    vecs[12] = mk(1'b1,1'b0,1'b1,1'b0,c_ill,  x_nop,  m_nop, w_nop, 8'd1);
    vecs[13] = mk(1'b1,1'b0,1'b1,1'b1,c_addi, x_nop,  m_nop, w_nop, 8'd1);
    vecs[14] = mk(1'b1,1'b1,1'b0,1'b1,c_beq,  x_nop,  m_nop, w_nop, 8'd1);
    vecs[15] = mk(1'b1,1'b0,1'b0,1'b0,c_addi, x_addi, m_nop, w_nop, 8'd1);
    vecs[16] = mk(1'b1,1'b0,1'b0,1'b0,c_beq,  x_beq,  m_oth, w_nop, 8'd1);
    vecs[17] = mk(1'b1,1'b0,1'b0,1'b1,c_rt,   x_nop,  m_nop, w_rw,  8'd1);
    vecs[18] = mk(1'b0,1'b1,1'b1,1'b1,c_sw,   x_nop,  m_nop, w_nop, 8'd0);

    drive(1'b0, 1'b0, 1'b0, 1'b0, c_rt);
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].rst_n, vecs[i].stall, vecs[i].bubble, vecs[i].flush, vecs[i].op);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].ex, vecs[i].mem, vecs[i].wb, vecs[i].cnt);
    end

    // Stall held for three edges with LW in ID/EX and SW in EX/MEM
    drive(1'b0, 1'b0, 1'b0, 1'b0, c_rt); step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, c_sw); step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, c_lw); step();
    check_all("stall_pre", x_lw, m_sw, w_nop, 8'd0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, c_addi); step();
      check_all($sformatf("stall_hold%0d", k), x_lw, m_sw, w_nop, 8'd0);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, c_addi); step();
    check_all("stall_rel0", x_addi, m_lw, w_oth, 8'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, c_beq); step();
    check_all("stall_rel1", x_beq, m_oth, w_lw, 8'd0);

    // Illegal opcode for 300 edges: counter saturates, then reset clears it
    drive(1'b0, 1'b0, 1'b0, 1'b0, c_rt); step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, c_ill);
    for (int k = 1; k <= 300; k++) begin
      step();
      if (k == 1 || k == 254 || k == 255 || k == 256 || k == 300)
        check($sformatf("sat_cnt_%0d", k), 32'(ill_cnt), (k < 255) ? k : 255);
    end
    check_all("sat_end", x_nop, m_nop, w_nop, 8'd255);
    drive(1'b0, 1'b0, 1'b0, 1'b0, c_ill); step();
    check("sat_rst_cnt", 32'(ill_cnt), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, c_lw); step();
    check_all("post_rst_first", x_lw, m_nop, w_nop, 8'd0);

    // Reset mid-pipeline discards in-flight words
    drive(1'b1, 1'b0, 1'b0, 1'b0, c_sw); step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, c_addi); step();
    check_all("midrst", x_nop, m_nop, w_nop, 8'd0);

    // JAL through to WB
    drive(1'b1, 1'b0, 1'b0, 1'b0, c_jal); step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, c_addi); step();
    step();
`ifdef CTRL_PIPE_JAL_EN
    check_all("jal_wb", x_addi, m_oth, 4'b1101, 8'd0);
`else
    check_all("jal_wb", x_addi, m_oth, w_nop, 8'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
